// File: rtl/bf_instruction_sequencer.sv
// bf_instruction_sequencer
//   Opcode sequencer for the dekatron CPU. Fetches 4-bit opcodes from the
//   program ROM, decodes them to a one-hot command, and dispatches that
//   command to the execution units over a req/ack handshake. It also steps
//   the instruction pointer and resolves loop brackets by scanning forward
//   or backward with a nesting-depth counter.
//
// Ports
//   Clk        system clock, rising edge
//   Rst_n      synchronous active-low reset
//   Run        start / resume pulse (honoured only in IDLE)
//   Halt_Req   pause request, taken when an IP advance completes
//   Rom_Req    opcode fetch request        Rom_Ack / Rom_Data  fetch response
//   Ip_Step    one-position IP move        Ip_Dir (1 = back), Ip_Ready done
//   Ex_Req     execution request           Ex_Op one-hot opcode, Ex_Ack done
//   Data_Zero  current data cell is zero
//   Busy       running (not IDLE / HALTED) Halted  absorbing halt state
//   Err        sticky loop-depth overflow
module bf_instruction_sequencer #(
   parameter int unsigned DEPTH_W = 8
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Run,
   input  logic        Halt_Req,
   output logic        Rom_Req,
   input  logic        Rom_Ack,
   input  logic [3:0]  Rom_Data,
   output logic        Ip_Step,
   output logic        Ip_Dir,
   input  logic        Ip_Ready,
   output logic        Ex_Req,
   output logic [15:0] Ex_Op,
   input  logic        Ex_Ack,
   input  logic        Data_Zero,
   output logic        Busy,
   output logic        Halted,
   output logic        Err
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC,
      S_ADVANCE, S_SKIP_STEP, S_SKIP_FETCH, S_HALTED
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP        = 4'd0,
      OP_HALT       = 4'd1,
      OP_DATA_INC   = 4'd2,
      OP_DATA_DEC   = 4'd3,
      OP_AP_INC     = 4'd4,
      OP_AP_DEC     = 4'd5,
      OP_LOOP_BEGIN = 4'd6,
      OP_LOOP_END   = 4'd7,
      OP_OUT        = 4'd8,
      OP_IN         = 4'd9
   } opcode_t;

   localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

   state_t               state_q, state_d;
   logic [3:0]           op_q, op_d;
   logic                 dir_q, dir_d;
   logic [DEPTH_W-1:0]   depth_q, depth_d;
   logic                 err_q, err_d;
   logic [15:0]          ex_op_q, ex_op_d;
   logic                 rom_req_q, ip_step_q, ip_dir_q, ex_req_q, busy_q, halted_q;
   logic                 scan_inc, scan_dec;

   // During a scan the bracket that opened the scan deepens nesting and its
   // partner closes it; which is which depends on the scan direction.
   assign scan_inc = dir_q ? (Rom_Data == OP_LOOP_END)   : (Rom_Data == OP_LOOP_BEGIN);
   assign scan_dec = dir_q ? (Rom_Data == OP_LOOP_BEGIN) : (Rom_Data == OP_LOOP_END);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      dir_d   = dir_q;
      depth_d = depth_q;
      err_d   = err_q;
      ex_op_d = ex_op_q;
      unique case (state_q)
         S_IDLE:   if (Run) state_d = S_FETCH;
         S_FETCH:  if (Rom_Ack) begin
                      op_d    = Rom_Data;
                      state_d = S_DECODE;
                   end
         S_DECODE: begin
            case (op_q)
               OP_HALT: state_d = S_HALTED;
               OP_DATA_INC, OP_DATA_DEC, OP_AP_INC, OP_AP_DEC, OP_OUT, OP_IN: begin
                  ex_op_d = 16'd1 << op_q;
                  state_d = S_EXEC;
               end
               OP_LOOP_BEGIN: begin
                  if (Data_Zero) begin
                     dir_d   = 1'b0;
                     depth_d = DEPTH_W'(1);
                     state_d = S_SKIP_STEP;
                  end else begin
                     state_d = S_ADVANCE;
                  end
               end
               OP_LOOP_END: begin
                  if (!Data_Zero) begin
                     dir_d   = 1'b1;
                     depth_d = DEPTH_W'(1);
                     state_d = S_SKIP_STEP;
                  end else begin
                     state_d = S_ADVANCE;
                  end
               end
               default: state_d = S_ADVANCE;
            endcase
         end
         S_EXEC:   if (Ex_Ack) begin
                      ex_op_d = '0;
                      state_d = S_ADVANCE;
                   end
         S_ADVANCE: if (Ip_Ready) state_d = Halt_Req ? S_IDLE : S_FETCH;
         S_SKIP_STEP: if (Ip_Ready) state_d = S_SKIP_FETCH;
         S_SKIP_FETCH: begin
            if (Rom_Ack) begin
               state_d = S_SKIP_STEP;
               if (scan_inc) begin
                  if (depth_q == DEPTH_MAX) begin
                     err_d   = 1'b1;
                     state_d = S_HALTED;
                  end else begin
                     depth_d = depth_q + DEPTH_W'(1);
                  end
               end else if (scan_dec) begin
                  depth_d = depth_q - DEPTH_W'(1);
                  // Matching bracket found: the normal advance steps past it.
                  if (depth_d == '0) state_d = S_ADVANCE;
               end
            end
         end
         S_HALTED: state_d = S_HALTED;
      endcase
   end

   // Outputs are registered from the next state so they line up with the
   // state they belong to without any combinational path to the ports.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         dir_q     <= 1'b0;
         depth_q   <= '0;
         err_q     <= 1'b0;
         ex_op_q   <= '0;
         rom_req_q <= 1'b0;
         ip_step_q <= 1'b0;
         ip_dir_q  <= 1'b0;
         ex_req_q  <= 1'b0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         dir_q     <= dir_d;
         depth_q   <= depth_d;
         err_q     <= err_d;
         ex_op_q   <= ex_op_d;
         rom_req_q <= (state_d == S_FETCH) || (state_d == S_SKIP_FETCH);
         ip_step_q <= (state_d == S_ADVANCE) || (state_d == S_SKIP_STEP);
         ip_dir_q  <= (state_d == S_SKIP_STEP) && dir_d;
         ex_req_q  <= (state_d == S_EXEC);
         busy_q    <= !((state_d == S_IDLE) || (state_d == S_HALTED));
         halted_q  <= (state_d == S_HALTED);
      end
   end

   assign Rom_Req = rom_req_q;
   assign Ip_Step = ip_step_q;
   assign Ip_Dir  = ip_dir_q;
   assign Ex_Req  = ex_req_q;
   assign Ex_Op   = ex_op_q;
   assign Busy    = busy_q;
   assign Halted  = halted_q;
   assign Err     = err_q;

endmodule

// File: tb/tb_bf_instruction_sequencer.sv
module tb_bf_instruction_sequencer;

   localparam int unsigned DW = 2;
   localparam int DMAX = 3;

   logic        Clk = 1'b0, Rst_n = 1'b0, Run = 1'b0, Halt_Req = 1'b0;
   logic        Rom_Ack = 1'b0, Ip_Ready = 1'b0, Ex_Ack = 1'b0, Data_Zero = 1'b1;
   logic [3:0]  Rom_Data = 4'd0;
   logic        Rom_Req, Ip_Step, Ip_Dir, Ex_Req, Busy, Halted, Err;
   logic [15:0] Ex_Op;

   bf_instruction_sequencer #(.DEPTH_W(DW)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Halt_Req(Halt_Req),
      .Rom_Req(Rom_Req), .Rom_Ack(Rom_Ack), .Rom_Data(Rom_Data),
      .Ip_Step(Ip_Step), .Ip_Dir(Ip_Dir), .Ip_Ready(Ip_Ready),
      .Ex_Req(Ex_Req), .Ex_Op(Ex_Op), .Ex_Ack(Ex_Ack), .Data_Zero(Data_Zero),
      .Busy(Busy), .Halted(Halted), .Err(Err)
   );

   always #5 Clk = ~Clk;

   int tests = 0, fails = 0;
   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // environment: ROM, IP counter, data tape, execution units
   logic [3:0] prog [32];
   logic [7:0] tape [16];
   int ap = 0, ip_env = 0, n_steps = 0, n_bsteps = 0, n_fetch = 0;
   int mode = 1;            // 0 random acks, 1 zero-wait acks, 2 zero-wait but Ex never acked
   int rise_cyc[$];
   logic ex_req_prev = 1'b0;

   // reference results
   int exp_ip[$];
   int exp_op[$];
   int ref_ip, ref_steps, ref_bsteps;
   bit ref_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   always @(negedge Clk) begin
      // ROM
      if (Rom_Req && (mode != 0 || $urandom_range(0, 1) == 0)) begin
         Rom_Ack  = 1'b1;
         Rom_Data = prog[ip_env & 31];
         n_fetch++;
      end else begin
         Rom_Ack  = !Rom_Req && mode == 0 && $urandom_range(0, 7) == 0;
         Rom_Data = 4'($urandom);
      end
      // IP counter
      if (Ip_Step && (mode != 0 || $urandom_range(0, 1) == 0)) begin
         Ip_Ready = 1'b1;
         ip_env   = Ip_Dir ? ip_env - 1 : ip_env + 1;
         n_steps++;
         if (Ip_Dir) n_bsteps++;
      end else begin
         Ip_Ready = !Ip_Step && mode == 0 && $urandom_range(0, 7) == 0;
      end
      // execution units
      if (Ex_Req && mode != 2 && (mode == 1 || $urandom_range(0, 1) == 0)) begin
         Ex_Ack = 1'b1;
         if (exp_op.size() == 0) begin
            check("ex_unexpected", 32'(Ex_Op), 32'd0);
         end else begin
            check("ex_op", 32'(Ex_Op), 32'(16'h1 << exp_op[0]));
            check("ex_ip", ip_env, exp_ip[0]);
            void'(exp_op.pop_front());
            void'(exp_ip.pop_front());
         end
         case (Ex_Op)
            16'h0004: tape[ap] = tape[ap] + 8'd1;
            16'h0008: tape[ap] = tape[ap] - 8'd1;
            16'h0010: ap = (ap + 1) % 16;
            16'h0020: ap = (ap + 15) % 16;
            16'h0200: tape[ap] = 8'(ip_env & 3);
            default: ;
         endcase
      end else begin
         Ex_Ack = !Ex_Req && mode == 0 && $urandom_range(0, 7) == 0;
      end
      if (!Ex_Req) check("ex_op_idle", 32'(Ex_Op), 32'd0);
      Data_Zero = (tape[ap] == 8'd0);
      if (Ex_Req && !ex_req_prev) rise_cyc.push_back(cyc);
      ex_req_prev = Ex_Req;
   end

   // Instruction-level interpreter: what the program should do, step by step.
   task automatic ref_run(output bit ok);
      logic [7:0] t [16];
      int a, ip, n, op, d, j;
      bit done;
      for (int i = 0; i < 16; i++) t[i] = 8'd0;
      a = 0; ip = 0; n = 0; ok = 1'b1; done = 1'b0;
      exp_ip.delete(); exp_op.delete();
      ref_steps = 0; ref_bsteps = 0; ref_err = 1'b0;
      while (!done) begin
         if (n > 80 || ip < 0 || ip > 31) begin
            ok = 1'b0; done = 1'b1;
         end else begin
            n++;
            op = int'(prog[ip]);
            if (op == 1) begin
               done = 1'b1;
            end else begin
               if (op inside {2, 3, 4, 5, 8, 9}) begin
                  exp_ip.push_back(ip);
                  exp_op.push_back(op);
               end
               case (op)
                  2: t[a] = t[a] + 8'd1;
                  3: t[a] = t[a] - 8'd1;
                  4: a = (a + 1) % 16;
                  5: a = (a + 15) % 16;
                  9: t[a] = 8'(ip & 3);
                  default: ;
               endcase
               if ((op == 6 && t[a] == 0) || (op == 7 && t[a] != 0)) begin
                  d = 1; j = ip;
                  while (d > 0 && !ref_err && ok) begin
                     j = (op == 6) ? j + 1 : j - 1;
                     ref_steps++;
                     if (op == 7) ref_bsteps++;
                     if (j < 0 || j > 31) ok = 1'b0;
                     else if (int'(prog[j]) == op) begin
                        if (d == DMAX) ref_err = 1'b1;
                        else d++;
                     end else if (int'(prog[j]) == 13 - op) d--;
                  end
                  ip = j;
                  if (ref_err || !ok) done = 1'b1;
               end
               if (!done) begin
                  ip++;
                  ref_steps++;
               end
            end
         end
      end
      ref_ip = ip;
   endtask

   task automatic load(input int n, input logic [63:0] p);
      for (int i = 0; i < 32; i++) prog[i] = 4'd1;
      for (int i = 0; i < n; i++) prog[i] = p[4*i +: 4];
   endtask

   task automatic gen_prog();
      int open, len, r;
      open = 0;
      len  = $urandom_range(6, 20);
      for (int i = 0; i < 32; i++) prog[i] = 4'd1;
      for (int k = 0; k < len; k++) begin
         r = $urandom_range(0, 9);
         if (r < 2 && open < 4) begin prog[k] = 4'd6; open++; end
         else if (r < 4 && open > 0) begin prog[k] = 4'd7; open--; end
         else if (r < 6) prog[k] = 4'd3;
         else begin
            case ($urandom_range(0, 7))
               0: prog[k] = 4'd0;
               1: prog[k] = 4'd2;
               2: prog[k] = 4'd4;
               3: prog[k] = 4'd5;
               4: prog[k] = 4'd8;
               5: prog[k] = 4'd9;
               6: prog[k] = 4'd12;
               default: prog[k] = 4'd15;
            endcase
         end
      end
      for (int k = len; open > 0; k++) begin
         prog[k] = 4'd7;
         open--;
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rom_req"}, 32'(Rom_Req), 32'd0);
      check({tag, "_ip_step"}, 32'(Ip_Step), 32'd0);
      check({tag, "_ip_dir"},  32'(Ip_Dir),  32'd0);
      check({tag, "_ex_req"},  32'(Ex_Req),  32'd0);
      check({tag, "_ex_op"},   32'(Ex_Op),   32'd0);
      check({tag, "_busy"},    32'(Busy),    32'd0);
   endtask

   task automatic do_reset();
      Rst_n = 1'b0; Run = 1'b0; Halt_Req = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      ip_env = 0; ap = 0; n_steps = 0; n_bsteps = 0; n_fetch = 0;
      for (int i = 0; i < 16; i++) tape[i] = 8'd0;
      rise_cyc.delete();
      ex_req_prev = 1'b0;
      check_idle_outputs("rst");
      check("rst_halted", 32'(Halted), 32'd0);
      check("rst_err",    32'(Err),    32'd0);
      Rst_n = 1'b1;
   endtask

   task automatic run_prog(input string tag, input bit rand_halt);
      int lim;
      lim = 0;
      while (Halted !== 1'b1 && lim < 20000) begin
         Run      = (Busy === 1'b0);
         Halt_Req = rand_halt && $urandom_range(0, 7) == 0;
         @(negedge Clk);
         lim++;
      end
      Run = 1'b0; Halt_Req = 1'b0;
      check({tag, "_halted"},  32'(Halted), 32'd1);
      check({tag, "_err"},     32'(Err), 32'(ref_err));
      check({tag, "_ip"},      ip_env, ref_ip);
      check({tag, "_steps"},   n_steps, ref_steps);
      check({tag, "_bsteps"},  n_bsteps, ref_bsteps);
      check({tag, "_ex_left"}, exp_op.size(), 32'd0);
      check_idle_outputs(tag);
   endtask

   initial begin
      bit ok;
      for (int i = 0; i < 16; i++) tape[i] = 8'd0;
      load(1, 64'h1);

      // 2,2,1 with zero-wait acks: two DATA_INC, 4 cycles apart
      mode = 1;
      load(3, 64'h122);
      do_reset();
      ref_run(ok);
      run_prog("inc2", 1'b0);
      check("inc2_rises", rise_cyc.size(), 32'd2);
      if (rise_cyc.size() == 2) check("inc2_gap", rise_cyc[1] - rise_cyc[0], 32'd4);
      check("inc2_fetches", n_fetch, 32'd3);

      // forward scan over a nested pair
      mode = 0;
      load(7, 64'h1773626);
      do_reset();
      ref_run(ok);
      run_prog("fwd", 1'b0);
      check("fwd_ip6", ip_env, 32'd6);

      // backward scan
      load(6, 64'h173622);
      do_reset();
      ref_run(ok);
      run_prog("bwd", 1'b0);

      // depth overflow with a 2-bit counter
      load(4, 64'h6666);
      do_reset();
      ref_run(ok);
      run_prog("ovf", 1'b0);
      check("ovf_err_set", 32'(Err), 32'd1);

      // reset while an execution request is outstanding
      mode = 2;
      load(2, 64'h12);
      do_reset();
      ref_run(ok);
      Run = 1'b1;
      @(negedge Clk);
      Run = 1'b0;
      for (int i = 0; i < 50 && Ex_Req !== 1'b1; i++) @(negedge Clk);
      check("mid_ex_req", 32'(Ex_Req), 32'd1);
      Rst_n = 1'b0;
      @(negedge Clk);
      check_idle_outputs("mid_rst");
      check("mid_rst_halted", 32'(Halted), 32'd0);
      check("mid_rst_err",    32'(Err),    32'd0);
      Rst_n = 1'b1;
      Run = 1'b1;
      @(negedge Clk);
      Run = 1'b0;
      check("mid_restart_rom_req", 32'(Rom_Req), 32'd1);
      check("mid_restart_busy",    32'(Busy),    32'd1);

      // pause after the first instruction, then resume
      mode = 1;
      load(4, 64'h1222);
      do_reset();
      ref_run(ok);
      Halt_Req = 1'b1;
      Run = 1'b1;
      @(negedge Clk);
      Run = 1'b0;
      for (int i = 0; i < 50 && Busy !== 1'b0; i++) @(negedge Clk);
      check("pause_busy",    32'(Busy),    32'd0);
      check("pause_halted",  32'(Halted),  32'd0);
      check("pause_ip",      ip_env,       32'd1);
      check("pause_fetches", n_fetch,      32'd1);
      repeat (3) @(negedge Clk);
      check("pause_rom_req", 32'(Rom_Req), 32'd0);
      check("pause_fetches_held", n_fetch, 32'd1);
      Halt_Req = 1'b0;
      run_prog("resume", 1'b0);

      // reserved opcode behaves as NOP
      mode = 0;
      load(3, 64'h12C);
      do_reset();
      ref_run(ok);
      run_prog("rsvd", 1'b0);

      // random programs with random handshake timing and pauses
      for (int p = 0; p < 10; p++) begin
         do_reset();
         ok = 1'b0;
         for (int tries = 0; tries < 200 && !ok; tries++) begin
            gen_prog();
            ref_run(ok);
         end
         if (ok) run_prog("rand", 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
